// File: rtl/shift_pipe_if.sv
// Handshake bundle for shift_pipe: request side (in_*) and result side (out_*).
// The slave modport is the shift unit; the master modport is whoever drives it.
interface shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SW-1:0]    in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, out_tag
    );
endinterface

// File: rtl/shift_pipe.sv
// Two-stage pipelined shifter (SLL/SRL/SRA/ROL) with carry and zero flags.
// Stage 1 shifts by shamt[1:0]; stage 2 shifts by the remaining multiple of 4.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    shift_pipe_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic [SW-1:0]    amt
    );
        logic [2*WIDTH-1:0] dbl;
        dbl      = {d, d} << amt;
        shift_by = '0;
        case (op)
            2'b00:   shift_by = d << amt;
            2'b01:   shift_by = d >> amt;
            2'b10:   shift_by = $unsigned($signed(d) >>> amt);
            default: shift_by = dbl[2*WIDTH-1:WIDTH];
        endcase
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [1:0]       s1_op;
    logic [SW-1:0]    s1_shamt;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_carry;

    logic             s2_adv;
    logic             s1_adv;
    logic [SW-1:0]    lo_amt;
    logic [SW-1:0]    hi_amt;
    logic [SW-1:0]    lidx;
    logic [SW-1:0]    ridx;
    logic [WIDTH-1:0] s1_next;
    logic [WIDTH-1:0] s2_next;
    logic             carry_next;

    always_comb begin
        s2_adv      = !bus.out_valid || bus.out_ready;
        s1_adv      = !s1_valid || s2_adv;
        bus.in_ready = s1_adv;
    end

    // Carry depends only on the original operand and full shamt, so it is
    // resolved in stage 1; for ROL in_data[WIDTH-shamt] is the final bit 0.
    always_comb begin
        lo_amt     = SW'(bus.in_shamt[1:0]);
        lidx       = '0 - bus.in_shamt;
        ridx       = bus.in_shamt - SW'(1);
        s1_next    = shift_by(bus.in_data, bus.in_op, lo_amt);
        carry_next = 1'b0;
        if (bus.in_shamt != '0) begin
            if (bus.in_op == 2'b01 || bus.in_op == 2'b10)
                carry_next = bus.in_data[ridx];
            else
                carry_next = bus.in_data[lidx];
        end
    end

    // Stage-1 SRA keeps the original sign in the MSB because it shifts by at most 3.
    always_comb begin
        hi_amt  = s1_shamt & ~SW'(3);
        s2_next = shift_by(s1_data, s1_op, hi_amt);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid      <= 1'b0;
            s1_data       <= '0;
            s1_op         <= '0;
            s1_shamt      <= '0;
            s1_tag        <= '0;
            s1_carry      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_carry <= 1'b0;
            bus.out_zero  <= 1'b0;
            bus.out_tag   <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
            end
            if (s1_adv && bus.in_valid) begin
                s1_data  <= s1_next;
                s1_op    <= bus.in_op;
                s1_shamt <= bus.in_shamt;
                s1_tag   <= bus.in_tag;
                s1_carry <= carry_next;
            end
            if (s2_adv) begin
                bus.out_valid <= s1_valid;
            end
            if (s2_adv && s1_valid) begin
                bus.out_data  <= s2_next;
                bus.out_carry <= s1_carry;
                bus.out_zero  <= (s2_next == '0);
                bus.out_tag   <= s1_tag;
            end
        end
    end
endmodule
